// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types and constants for the Simon pattern playback sequencer
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHOW  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } simon_state_e;

  localparam logic [3:0] LED_BLANK = 4'b0000;

  // Timer must hold the larger of the two phase lengths minus one.
  function automatic int timer_width(input int on_cycles, input int off_cycles);
    int m;
    m = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/simon_down_timer.sv
// rtl/simon_down_timer.sv - loadable down counter that parks at zero
module simon_down_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/simon_playback_seq.sv
// rtl/simon_playback_seq.sv - replays stored LED patterns from a synchronous-read memory
// Each pattern: fetch, load, ON_CYCLES lit, OFF_CYCLES blank; done pulses after the last one.
module simon_playback_seq
  import simon_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int ON_CYCLES  = 3,
  parameter int OFF_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W:0]   count_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [3:0]        rd_data_i,
  output logic [3:0]        leds_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int TMR_W = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TMR_W-1:0] ON_VAL  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_VAL = TMR_W'(OFF_CYCLES - 1);

  simon_state_e      state_q;
  logic [ADDR_W:0]   idx_q;
  logic [ADDR_W:0]   cnt_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [3:0]        leds_q;
  logic              busy_q;
  logic              done_q;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;
  logic [ADDR_W:0]   idx_inc;

  assign idx_inc = idx_q + {{ADDR_W{1'b0}}, 1'b1};

  // Same timer serves both phases: ON length loaded in LOAD, OFF length on SHOW exit.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_q == S_LOAD) begin
      tmr_load = 1'b1;
      tmr_val  = ON_VAL;
    end else if (state_q == S_SHOW && tmr_zero) begin
      tmr_load = 1'b1;
      tmr_val  = OFF_VAL;
    end
  end

  simon_down_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      leds_q    <= LED_BLANK;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (abort_i && state_q != S_IDLE) begin
      state_q   <= S_IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      leds_q    <= LED_BLANK;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            busy_q <= 1'b1;
            if (count_i != '0) begin
              state_q <= S_FETCH;
              idx_q   <= '0;
              cnt_q   <= count_i;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          leds_q  <= rd_data_i;
          state_q <= S_SHOW;
        end
        S_SHOW: begin
          if (tmr_zero) begin
            leds_q  <= LED_BLANK;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (tmr_zero) begin
            if (idx_inc < cnt_q) begin
              idx_q     <= idx_inc;
              rd_en_q   <= 1'b1;
              rd_addr_q <= idx_inc[ADDR_W-1:0];
              state_q   <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          leds_q  <= LED_BLANK;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign leds_o    = leds_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_simon_playback_seq.sv
// tb/tb_simon_playback_seq.sv - randomized self-checking bench for simon_playback_seq
module tb_simon_playback_seq;

  localparam int ADDR_W = 2;
  localparam int ON     = 3;
  localparam int OFF    = 2;
  localparam int P      = 2 + ON + OFF;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        rd_data;
  logic [3:0]        leds;
  logic              busy;
  logic              done;

  logic [3:0] mem [4];
  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  simon_playback_seq #(
    .ADDR_W     (ADDR_W),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .abort_i   (abort),
    .count_i   (count),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data),
    .leds_o    (leds),
    .busy_o    (busy),
    .done_o    (done)
  );

  // Synchronous-read pattern memory; garbage on the bus when not read.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    else       rd_data <= 4'($urandom);
  end

  // Expected {rd_en, rd_addr, leds, busy, done} in cycle c after a start in cycle 0.
  function automatic logic [8:0] model(input int c, input int n);
    int last, k, p;
    logic       re;
    logic [1:0] addr;
    logic [3:0] lv;
    last = (n == 0) ? 1 : n * P + 1;
    if (c < 1 || c > last) return 9'b0;
    if (c == last) return 9'b0_00_0000_1_1;
    k    = (c - 1) / P;
    p    = (c - 1) % P;
    re   = (p == 0);
    addr = re ? 2'(k) : 2'b00;
    lv   = (p >= 2 && p < 2 + ON) ? mem[k] : 4'b0000;
    return {re, addr, lv, 1'b1, 1'b0};
  endfunction

  function automatic int last_cycle(input int n);
    return (n == 0) ? 1 : n * P + 1;
  endfunction

  task automatic randomize_mem();
    for (int i = 0; i < 4; i++) mem[i] = 4'($urandom);
  endtask

  // ab/rs/rc: cycle in which abort / extra start / reset is held high (-1 = never).
  task automatic play(input string name, input int n, input int ab, input int rs, input int rc);
    int last;
    logic [8:0] exp_v, got_v;
    last = last_cycle(n);
    @(posedge clk); #1;
    count = 3'(n);
    start = 1'b1;
    abort = 1'b0;
    rst   = 1'b0;
    for (int c = 0; c <= last + 3; c++) begin
      @(negedge clk);
      if ((ab >= 0 && c > ab) || (rc >= 0 && c > rc)) exp_v = 9'b0;
      else exp_v = model(c, n);
      got_v = {rd_en, rd_addr, leds, busy, done};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL %s n=%0d cyc=%0d {rd_en,addr,leds,busy,done} got=%b_%b_%b_%b_%b exp=%b_%b_%b_%b_%b",
                 name, n, c, got_v[8], got_v[7:6], got_v[5:2], got_v[1], got_v[0],
                 exp_v[8], exp_v[7:6], exp_v[5:2], exp_v[1], exp_v[0]);
      end
      @(posedge clk); #1;
      start = (c + 1 == rs);
      abort = (c + 1 == ab);
      rst   = (c + 1 == rc);
      count = 3'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0; count = 3'd2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({rd_en, rd_addr, leds, busy, done} !== 9'b0) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, {rd_en, rd_addr, leds, busy, done}, 9'b0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_basic();
    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'($urandom); mem[3] = 4'($urandom);
    play("basic", 2, -1, -1, -1);
  endtask

  task automatic test_zero_count();
    randomize_mem();
    play("zero_count", 0, -1, -1, -1);
  endtask

  task automatic test_full_count();
    randomize_mem();
    play("full_count", 4, -1, -1, -1);
  endtask

  task automatic test_abort();
    randomize_mem();
    play("abort_show2", 2, 11, -1, -1);
    randomize_mem();
    play("abort_done", 1, last_cycle(1), -1, -1);
    randomize_mem();
    play("abort_fetch", 3, 1, -1, -1);
  endtask

  task automatic test_restart_in_gap();
    mem[0] = 4'b0001; mem[1] = 4'b0100;
    play("restart_gap", 2, -1, 6, -1);
  endtask

  task automatic test_reset_mid_show();
    randomize_mem();
    play("rst_show", 2, -1, -1, 4);
    play("after_rst", 2, -1, -1, -1);
  endtask

  task automatic test_abort_priority();
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; count = 3'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({rd_en, rd_addr, leds, busy, done} !== 9'b0) begin
        miscompares++;
        $display("FAIL abort_priority cyc=%0d got=%b exp=%b", i, {rd_en, rd_addr, leds, busy, done}, 9'b0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int n, last, ab, rs;
    for (int it = 0; it < 20; it++) begin
      randomize_mem();
      n    = $urandom_range(0, 4);
      last = last_cycle(n);
      ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, last)) : -1;
      rs   = (ab < 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, last)) : -1;
      play("random", n, ab, rs, -1);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; count = '0; rd_data = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_zero_count();
    test_full_count();
    test_abort();
    test_restart_in_gap();
    test_reset_mid_show();
    test_abort_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/simon_playback_seq.md
SIMON_PLAYBACK_SEQ -- requirements
Module: simon_playback_seq

Interface
REQ-001 Parameter ADDR_W, default 6: pattern memory address width.
REQ-002 Parameter ON_CYCLES, default 3: cycles each pattern is lit; legal range >= 1.
REQ-003 Parameter OFF_CYCLES, default 2: blank cycles after each pattern; legal range >= 1.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin playback; sampled only in IDLE.
REQ-007 abort  input  1  cancel playback from any state.
REQ-008 count  input  ADDR_W+1  number of stored patterns to play, 0..2^ADDR_W; sampled with start.
REQ-009 rd_en  output  1  pattern memory read strobe.
REQ-010 rd_addr  output  ADDR_W  pattern memory read address.
REQ-011 rd_data  input  4  memory data, valid in the cycle after rd_en (synchronous read).
REQ-012 leds  output  4  pattern being displayed; registered.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on completed playback.

Function
REQ-015 States: IDLE, FETCH, LOAD, SHOW, GAP, DONE.
REQ-016 IDLE: start=1, count>0 -> FETCH, index<=0, count latched; start=1, count=0 -> DONE; otherwise stay.
REQ-017 FETCH: rd_en=1, rd_addr=index; one cycle; -> LOAD.
REQ-018 LOAD: leds register captures rd_data at end of cycle; timer<=ON_CYCLES-1; -> SHOW.
REQ-019 SHOW: leds = captured pattern; lasts exactly ON_CYCLES cycles; on exit leds cleared, timer<=OFF_CYCLES-1; -> GAP.
REQ-020 GAP: leds=0; lasts exactly OFF_CYCLES cycles; then index+1 < latched count -> FETCH with index incremented, else -> DONE.
REQ-021 DONE: done=1 for one cycle; -> IDLE.
REQ-022 Per-pattern duration: 2+ON_CYCLES+OFF_CYCLES cycles; done asserted N*(2+ON_CYCLES+OFF_CYCLES)+1 cycles after the start edge for count=N>0; 1 cycle after for count=0.
REQ-023 rd_en=0 and rd_addr=0 outside FETCH; leds=0 outside SHOW.
REQ-024 index width ADDR_W+1 internally; count=2^ADDR_W plays all addresses 0..2^ADDR_W-1 with no address wrap.
REQ-025 Timer width $clog2 of max(ON_CYCLES,OFF_CYCLES)+1; counts down, no wrap.
REQ-026 start while busy ignored; count changes while busy ignored.
REQ-027 abort in any non-IDLE state -> IDLE next cycle, leds=0, no done pulse; abort has priority over start in the same cycle.
REQ-028 abort and the DONE state in the same cycle: done still pulses in that cycle, next state IDLE.

Reset
REQ-029 rst=1 at a rising edge: state IDLE, index=0, timer=0, leds=0, rd_en=0, rd_addr=0, busy=0, done=0.
REQ-030 rst has priority over abort and start; reset mid-playback discards all progress.

Structure
REQ-031 State encoding enum and LED blank constant (4'b0000) belong in the shared simon package.
REQ-032 One sub-module: simon_down_timer (load value, load strobe, zero flag), reused for ON and OFF phases.
REQ-033 Single always-block next-state logic plus registered outputs; no combinational path from rd_data to leds.

Verification
REQ-034 ON=3, OFF=2, count=2, memory {4'b0001, 4'b0100}, start at cycle 0 -> rd_en at cycles 1 and 8, leds=0001 cycles 3-5, leds=0100 cycles 10-12, done at cycle 15 only.
REQ-035 count=0, start -> done at cycle 1, rd_en never asserted, busy high for cycle 1 only.
REQ-036 count=2, abort during second SHOW -> IDLE next cycle, leds=0, done never asserted.
REQ-037 start pulsed again during GAP -> ignored; playback sequence and done timing identical to REQ-034.
REQ-038 ADDR_W=2, count=4 -> rd_addr sequence 0,1,2,3, then done; no fifth read.
REQ-039 rst asserted mid-SHOW -> next cycle all outputs at reset values; subsequent start replays from address 0.
